// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the MII transmit framer.
//   state_e      - framer FSM states
//   PREAMBLE_NIB - nibble repeated during the preamble
//   SFD_NIB      - start-of-frame delimiter nibble
//   CRC_POLY     - reflected CRC-32 polynomial
//   CRC_INIT     - CRC-32 seed value
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        PAD,
        FCS,
        IFG,
        DROP
    } state_e;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: combinational one-byte step of the reflected Ethernet CRC-32.
//   crc_i  [31:0] in   running CRC before this byte
//   data_i [7:0]  in   byte to fold in (bit 0 first on the wire)
//   crc_o  [31:0] out  running CRC after this byte
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/mii_tx_framer.sv
// mii_tx_framer: byte-stream to MII transmit framer (phy_tx_clk domain).
// Adds preamble/SFD, pads short frames with zeros, appends the CRC-32 FCS
// and holds off the next frame for the inter-frame gap.
//   clk, rst_n          nibble clock, async active-low reset
//   s_tdata/s_tvalid/   payload byte stream (dest MAC .. end of payload),
//   s_tready/s_tlast    byte moves when s_tvalid && s_tready
//   phy_txd/phy_tx_en/  MII transmit pins, low nibble of each byte first
//   phy_tx_er
//   tx_busy             high whenever the FSM is not IDLE
//   frame_done          pulse with the last FCS nibble
//   underflow           pulse with the error nibble of an aborted frame
module mii_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    output logic [3:0] phy_txd,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       underflow
);

    // The IDLE cycle that sees the next s_tvalid is itself a silent cycle,
    // so IFG holds one cycle less and the line stays quiet 2*IFG_BYTES cycles.
    localparam int          IFG_CYC  = (IFG_BYTES > 0) ? 2 * IFG_BYTES - 1 : 0;
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYC - 1);
    localparam state_e      GAP_ST   = (IFG_CYC > 0) ? IFG : IDLE;
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;      // cycle counter for PREAMBLE/FCS/IFG
    logic        phase_q, phase_d;  // 0 = low nibble, 1 = high nibble
    logic [7:0]  data_q, data_d;
    logic        last_q, last_d;
    logic        err_q, err_d;      // first DROP cycle carries the error nibble
    logic [15:0] bcnt_q, bcnt_d;    // bytes sent, saturating at MIN_FRAME
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_next;
    logic [15:0] bcnt_inc;
    logic [31:0] fcs_w;

    logic [3:0]  txd_d;
    logic        en_d, er_d, rdy_d, busy_d, done_d, uf_d;

    eth_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i ((state_q == PAD) ? 8'h00 : data_q),
        .crc_o  (crc_next)
    );

    assign bcnt_inc = (bcnt_q >= MIN_LEN) ? bcnt_q : bcnt_q + 16'd1;

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        data_d  = data_q;
        last_d  = last_q;
        err_d   = err_q;
        bcnt_d  = bcnt_q;
        crc_d   = crc_q;
        case (state_q)
            IDLE: if (s_tvalid) begin
                state_d = PREAMBLE;
                cnt_d   = 8'd0;
                phase_d = 1'b0;
                err_d   = 1'b0;
                bcnt_d  = 16'd0;
                crc_d   = CRC_INIT;
            end
            PREAMBLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd14) state_d = SFD;
            end
            SFD: if (s_tvalid) begin
                data_d  = s_tdata;
                last_d  = s_tlast;
                phase_d = 1'b0;
                state_d = PAYLOAD;
            end else begin
                state_d = DROP;
                err_d   = 1'b1;
            end
            PAYLOAD: if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                crc_d   = crc_next;
                bcnt_d  = bcnt_inc;
                if (last_q) begin
                    state_d = (bcnt_inc < MIN_LEN) ? PAD : FCS;
                    cnt_d   = 8'd0;
                end else if (s_tvalid) begin
                    data_d = s_tdata;
                    last_d = s_tlast;
                end else begin
                    state_d = DROP;
                    err_d   = 1'b1;
                end
            end
            PAD: if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                crc_d   = crc_next;
                bcnt_d  = bcnt_inc;
                if (bcnt_inc >= MIN_LEN) begin
                    state_d = FCS;
                    cnt_d   = 8'd0;
                end
            end
            FCS: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd7) begin
                    state_d = GAP_ST;
                    cnt_d   = 8'd0;
                end
            end
            IFG: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == IFG_LAST) state_d = IDLE;
            end
            DROP: begin
                err_d = 1'b0;
                if (s_tready && s_tvalid && s_tlast) begin
                    state_d = GAP_ST;
                    cnt_d   = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and then registered, so each
    // output register always reflects the state register it is loaded with.
    assign fcs_w = ~crc_d;

    always_comb begin : outputs
        txd_d  = 4'h0;
        en_d   = 1'b0;
        er_d   = 1'b0;
        rdy_d  = 1'b0;
        done_d = 1'b0;
        uf_d   = 1'b0;
        busy_d = (state_d != IDLE);
        case (state_d)
            PREAMBLE: begin
                en_d  = 1'b1;
                txd_d = PREAMBLE_NIB;
            end
            SFD: begin
                en_d  = 1'b1;
                txd_d = SFD_NIB;
                rdy_d = 1'b1;
            end
            PAYLOAD: begin
                en_d  = 1'b1;
                txd_d = phase_d ? data_d[7:4] : data_d[3:0];
                rdy_d = phase_d && !last_d;
            end
            PAD: en_d = 1'b1;
            FCS: begin
                en_d   = 1'b1;
                txd_d  = fcs_w[{cnt_d[2:0], 2'b00} +: 4];
                done_d = (cnt_d == 8'd7);
            end
            DROP: if (err_d) begin
                en_d = 1'b1;
                er_d = 1'b1;
                uf_d = 1'b1;
            end else begin
                rdy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            phase_q    <= 1'b0;
            data_q     <= 8'd0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            bcnt_q     <= 16'd0;
            crc_q      <= 32'd0;
            phy_txd    <= 4'h0;
            phy_tx_en  <= 1'b0;
            phy_tx_er  <= 1'b0;
            s_tready   <= 1'b0;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            data_q     <= data_d;
            last_q     <= last_d;
            err_q      <= err_d;
            bcnt_q     <= bcnt_d;
            crc_q      <= crc_d;
            phy_txd    <= txd_d;
            phy_tx_en  <= en_d;
            phy_tx_er  <= er_d;
            s_tready   <= rdy_d;
            tx_busy    <= busy_d;
            frame_done <= done_d;
            underflow  <= uf_d;
        end
    end

endmodule

// File: tb/tb_mii_tx_framer.sv
// tb_mii_tx_framer: directed bench for mii_tx_framer. dut0 runs with
// MIN_FRAME=0, dut1 with defaults; sel_r picks which one the stream drives.
module tb_mii_tx_framer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tdata = 8'h00;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic       sel_r = 1'b0;

    logic [3:0] txd0, txd1;
    logic en0, en1, er0, er1, rdy0, rdy1, busy0, busy1, done0, done1, uf0, uf1;

    mii_tx_framer #(.MIN_FRAME(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_tdata(tdata), .s_tvalid(tvalid && !sel_r),
        .s_tready(rdy0), .s_tlast(tlast), .phy_txd(txd0), .phy_tx_en(en0),
        .phy_tx_er(er0), .tx_busy(busy0), .frame_done(done0), .underflow(uf0)
    );

    mii_tx_framer dut1 (
        .clk(clk), .rst_n(rst_n), .s_tdata(tdata), .s_tvalid(tvalid && sel_r),
        .s_tready(rdy1), .s_tlast(tlast), .phy_txd(txd1), .phy_tx_en(en1),
        .phy_tx_er(er1), .tx_busy(busy1), .frame_done(done1), .underflow(uf1)
    );

    typedef struct packed {
        logic en, er, rdy, done, uf, busy;
        logic [3:0] txd;
    } smp_t;

    smp_t cur;
    logic rdy_sel, busy_sel;
    assign cur = sel_r ? {en1, er1, rdy1, done1, uf1, busy1, txd1}
                       : {en0, er0, rdy0, done0, uf0, busy0, txd0};
    assign rdy_sel  = sel_r ? rdy1 : rdy0;
    assign busy_sel = sel_r ? busy1 : busy0;

    smp_t       log_q[$];
    logic       mon_on = 1'b0;
    logic [3:0] exp_q[$];
    logic [7:0] pay_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    always @(posedge clk) begin
        #1;
        if (mon_on) log_q.push_back(cur);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_t(input string nm, input int a, input int e);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", nm, a, e);
    endtask

    // Bit-serial reference CRC, LSB of each byte first.
    function automatic logic [31:0] crc_model(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        logic fb;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    task automatic build_exp(input logic [7:0] q[$], input int minf);
        logic [7:0]  p[$];
        logic [31:0] f;
        p = q;
        exp_q.delete();
        repeat (15) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        while (p.size() < minf) p.push_back(8'h00);
        foreach (p[i]) begin
            exp_q.push_back(p[i][3:0]);
            exp_q.push_back(p[i][7:4]);
        end
        f = ~crc_model(p);
        for (int i = 0; i < 8; i++) exp_q.push_back(f[4*i +: 4]);
    endtask

    task automatic make_payload(input int len, input int pat);
        pay_q.delete();
        for (int i = 0; i < len; i++) begin
            case (pat)
                0:       pay_q.push_back(8'h31 + 8'(i));
                1:       pay_q.push_back(8'hAB);
                2:       pay_q.push_back(8'($urandom));
                default: pay_q.push_back(8'(i));
            endcase
        end
    endtask

    // k-th contiguous run of phy_tx_en high in the log.
    task automatic get_run(input int k, output int st, output int ln);
        int n = 0;
        st = -1;
        ln = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].en && (i == 0 || !log_q[i-1].en)) begin
                if (n == k) begin
                    st = i;
                    while (i + ln < log_q.size() && log_q[i+ln].en) ln++;
                end
                n++;
            end
        end
    endtask

    function automatic int cnt_field(input int f, input int a, input int b);
        int n = 0;
        for (int i = (a < 0 ? 0 : a); i < b && i < log_q.size(); i++) begin
            case (f)
                0:       n += int'(log_q[i].done);
                1:       n += int'(log_q[i].er);
                2:       n += int'(log_q[i].uf);
                default: n += int'(log_q[i].rdy);
            endcase
        end
        return n;
    endfunction

    function automatic int first_idx(input int f);
        for (int i = 0; i < log_q.size(); i++) begin
            if ((f == 0 && log_q[i].done) || (f == 1 && log_q[i].er)) return i;
        end
        return -1;
    endfunction

    task automatic chk_stream(input string nm, input int st, input int ln,
                              input logic [7:0] q[$], input int minf);
        int bad = -1;
        build_exp(q, minf);
        n_cmp++;
        if (st < 0 || ln != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s: got %0d nibbles expected %0d", nm, ln, exp_q.size());
        end else begin
            for (int i = 0; i < ln; i++)
                if (bad < 0 && log_q[st+i].txd !== exp_q[i]) bad = i;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL %s: nibble %0d got %0h expected %0h",
                         nm, bad, log_q[st+bad].txd, exp_q[bad]);
            end
        end
    endtask

    task automatic drive(input logic [7:0] q[$], input int stall_at, input int stall_len,
                         input int abort_at, input bit hold);
        int idx = 0;
        int sc = 0;
        int cyc = 0;
        while (idx < q.size()) begin
            if (idx == abort_at) break;
            @(negedge clk);
            cyc++;
            if (cyc > 8000) begin
                fail_t("drive_timeout", idx, q.size());
                break;
            end
            if (idx == stall_at && sc < stall_len) begin
                tvalid = 1'b0;
                sc++;
            end else begin
                tvalid = 1'b1;
                tdata  = q[idx];
                tlast  = (idx == q.size() - 1);
                if (rdy_sel) idx++;
            end
        end
        if (!hold) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        @(negedge clk);
        while (busy_sel && c < 10000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 10000) fail_t("idle_timeout", c, 10000);
        @(negedge clk);
    endtask

    task automatic run_frame(input string nm, input bit sel, input logic [7:0] q[$],
                             input int minf, input int exp_en, output int st, output int ln);
        sel_r = sel;
        log_q.delete();
        mon_on = 1'b1;
        drive(q, -1, 0, -1, 1'b0);
        wait_idle();
        mon_on = 1'b0;
        get_run(0, st, ln);
        chk({nm, ".en_cycles"}, ln, exp_en);
        chk_stream({nm, ".stream"}, st, ln, q, minf);
        chk({nm, ".done_cnt"}, cnt_field(0, 0, log_q.size()), 1);
        chk({nm, ".done_pos"}, first_idx(0), st + ln - 1);
        chk({nm, ".er_cnt"}, cnt_field(1, 0, log_q.size()), 0);
        chk({nm, ".uf_cnt"}, cnt_field(2, 0, log_q.size()), 0);
    endtask

    typedef struct {
        bit sel;
        int len;
        int pat;
        int minf;
        int exp_en;
    } vec_t;

    initial begin
        vec_t tbl[8];
        logic [7:0]  qa[$], qb[$];
        logic [31:0] f;
        int st, ln, st1, ln1, ep, len;

        tbl[0] = '{1'b0,    9, 0,  0,   42};
        tbl[1] = '{1'b1,    1, 1, 60,  144};
        tbl[2] = '{1'b1,   59, 3, 60,  144};
        tbl[3] = '{1'b1,   60, 3, 60,  144};
        tbl[4] = '{1'b1,   61, 2, 60,  146};
        tbl[5] = '{1'b0,    1, 1,  0,   26};
        tbl[6] = '{1'b1,  200, 2, 60,  424};
        tbl[7] = '{1'b1, 1500, 2, 60, 3024};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outs0", {txd0, en0, er0, rdy0, busy0, done0, uf0}, 0);
        chk("reset_outs1", {txd1, en1, er1, rdy1, busy1, done1, uf1}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold", {busy0, busy1, en0, en1, rdy0, rdy1}, 0);

        // Table of single frames
        for (int v = 0; v < 8; v++) begin
            make_payload(tbl[v].len, tbl[v].pat);
            run_frame($sformatf("vec%0d", v), tbl[v].sel, pay_q, tbl[v].minf,
                      tbl[v].exp_en, st, ln);
            if (v == 0 && st >= 0 && ln >= 8) begin
                for (int i = 0; i < 8; i++) f[4*i +: 4] = log_q[st+ln-8+i].txd;
                chk("vec0.fcs_const", f, 32'hCBF43926);
            end
        end

        // Back-to-back 64-byte frames, s_tvalid held through the gap
        sel_r = 1'b1;
        make_payload(64, 2); qa = pay_q;
        make_payload(64, 3); qb = pay_q;
        log_q.delete();
        mon_on = 1'b1;
        drive(qa, -1, 0, -1, 1'b1);
        drive(qb, -1, 0, -1, 1'b0);
        wait_idle();
        mon_on = 1'b0;
        get_run(0, st, ln);
        get_run(1, st1, ln1);
        chk("b2b.len0", ln, 152);
        chk("b2b.len1", ln1, 152);
        chk_stream("b2b.stream0", st, ln, qa, 60);
        chk_stream("b2b.stream1", st1, ln1, qb, 60);
        chk("b2b.gap", st1 - (st + ln), 24);
        chk("b2b.gap_rdy", cnt_field(3, st + ln, st1), 0);
        chk("b2b.done_cnt", cnt_field(0, 0, log_q.size()), 2);

        // Underflow after 10 of 20 bytes, followed by a clean frame
        make_payload(20, 3); qa = pay_q;
        make_payload(9, 0);  qb = pay_q;
        log_q.delete();
        mon_on = 1'b1;
        drive(qa, 10, 3, -1, 1'b1);
        drive(qb, -1, 0, -1, 1'b0);
        wait_idle();
        mon_on = 1'b0;
        get_run(0, st, ln);
        get_run(1, st1, ln1);
        ep = first_idx(1);
        chk("uf.abort_len", ln, 37);
        chk("uf.er_cnt", cnt_field(1, 0, log_q.size()), 1);
        chk("uf.er_pos", ep, st + ln - 1);
        chk("uf.uf_cnt", cnt_field(2, 0, log_q.size()), 1);
        if (ep >= 0) chk("uf.er_cycle", {log_q[ep].txd, log_q[ep].uf, log_q[ep].en}, {4'h0, 1'b1, 1'b1});
        else fail_t("uf.er_cycle", ep, st + ln - 1);
        chk("uf.gap", st1 - (st + ln), 34);
        chk("uf.drop_rdy", cnt_field(3, st + ln, st1), 10);
        chk("uf.done_cnt", cnt_field(0, 0, log_q.size()), 1);
        chk("uf.next_len", ln1, 144);
        chk_stream("uf.next_stream", st1, ln1, qb, 60);

        // Reset mid-payload, then a fresh frame
        sel_r = 1'b0;
        make_payload(9, 0); qa = pay_q;
        drive(qa, -1, 0, 4, 1'b1);
        @(posedge clk);
        #2;
        chk("rst.pre_en", en0, 1'b1);
        rst_n  = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        #1;
        chk("rst.outs", {txd0, en0, er0, rdy0, busy0, done0, uf0}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("rst.after", 1'b0, qa, 0, 42, st, ln);

        // Random lengths against the reference model
        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(1, 1500));
            make_payload(len, 2);
            run_frame($sformatf("rand%0d_len%0d", r, len), 1'b1, pay_q, 60,
                      2 * (8 + ((len > 60) ? len : 60) + 4), st, ln);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mii_tx_framer.md
Name: mii_tx_framer

Overview:
- Transmit-side MII framer; the counterpart of the receive path that fpga_core exposes on phy_rxd/phy_rx_dv.
- Accepts payload bytes (destination MAC through the end of the payload) on a byte stream and drives phy_txd/phy_tx_en, one nibble per clk.
- Adds the preamble and SFD, pads short frames, appends the CRC-32 FCS, and enforces the inter-frame gap.
- Sits between the UDP/ARP transmit stack and the 100BASE-T MII pins. clk is the phy_tx_clk domain.

Parameters:
- MIN_FRAME, 60: minimum bytes before the FCS; shorter frames are padded with 8'h00. A value of 0 disables padding.
- IFG_BYTES, 12: inter-frame gap in byte times. The gap lasts 2*IFG_BYTES clk cycles.

Ports:
- clk  in  1  nibble clock (25 MHz in hardware)
- rst_n  in  1  asynchronous, active-low reset
- s_tdata  in  8  payload byte
- s_tvalid  in  1  byte valid
- s_tready  out  1  byte accepted when s_tvalid && s_tready
- s_tlast  in  1  marks the last payload byte
- phy_txd  out  4  MII transmit nibble
- phy_tx_en  out  1  MII transmit enable
- phy_tx_er  out  1  MII transmit error
- tx_busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the last FCS nibble is sent
- underflow  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- All outputs are registered. While rst_n is low, every output is 0 and the state is IDLE. Reset may occur mid-frame; afterwards phy_tx_en is 0 and the next frame starts clean.
- Byte order: the low nibble goes out before the high nibble. A byte occupies two consecutive cycles, the L phase then the H phase.
- IDLE: s_tready=0. If s_tvalid is seen at cycle 0, go to PREAMBLE; phy_tx_en rises at cycle 1.
- PREAMBLE: 15 cycles of txd=4'h5.
- SFD: one cycle of txd=4'hD.
  - s_tready=1 in this cycle, so the first byte is loaded into the data register.
  - If s_tvalid=0 here, take the underflow path.
- PAYLOAD:
  - L phase: txd=data_reg[3:0].
  - H phase: txd=data_reg[7:4]. If the current byte was not tlast, s_tready=1 to load the next byte.
  - The byte counter (saturating at MIN_FRAME) increments once per byte.
  - After the tlast byte's H phase: go to PAD if count < MIN_FRAME, otherwise go to FCS.
- PAD: send 8'h00 bytes until count == MIN_FRAME. s_tready=0.
- FCS:
  - Sends ~crc as 4 bytes, least-significant byte first, low nibble first: 8 cycles.
  - CRC-32 uses reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, and covers payload and pad bytes.
  - frame_done pulses on the 8th FCS cycle.
- IFG: phy_tx_en=0, txd=0, s_tready=0 for 2*IFG_BYTES cycles, then go to IDLE.
  - A pending s_tvalid is held off and must not be accepted during the gap.
- Underflow: s_tready=1 and s_tvalid=0 in the same cycle during SFD or PAYLOAD.
  - Next cycle: phy_tx_en=1, phy_tx_er=1, txd=0 for one cycle, and underflow pulses.
  - Then go to DROP.
- DROP: s_tready=1 and phy_tx_en=0. Bytes are discarded through the byte with s_tlast, then go to IFG. No FCS is sent.
- A 1-byte frame with s_tlast set on the byte loaded in SFD is legal: 1 payload byte, 59 pad bytes, then FCS.
- Nibble-accurate timing: 16 cycles of preamble+SFD, then 2 cycles per byte.

Decomposition:
- eth_pkg:
  - state enum: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG, DROP
  - PREAMBLE_NIB=4'h5, SFD_NIB=4'hD
  - CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF
- Sub-module eth_crc32_byte:
  - Combinational next-CRC computed from crc_in[31:0] and byte[7:0].
  - Updated once per byte, in the H phase.

Test Plan:
- MIN_FRAME=0, payload "123456789" (8'h31..8'h39) -> 15×4'h5, 4'hD, nibbles 1,3,2,3..9,3, FCS bytes 26 39 F4 CB; phy_tx_en high for exactly 42 cycles; frame_done pulses once.
- Default params, 1-byte payload 8'hAB -> nibbles B,A, then 118 zero nibbles, then 8 FCS nibbles; phy_tx_en high for 144 cycles.
- Two back-to-back 64-byte frames with s_tvalid held high -> phy_tx_en low for exactly 24 cycles between them; s_tready stays 0 during the gap.
- s_tvalid dropped after 10 bytes of a 20-byte frame -> one cycle with phy_tx_er=1, underflow pulses, the remaining 10 bytes are consumed through tlast, no FCS, then a 24-cycle gap; the next frame is correct.
- rst_n asserted during PAYLOAD -> all outputs 0 immediately; after release, a fresh 9-byte frame matches the first scenario.
- Random payloads of 1–1500 bytes against a CRC reference model -> FCS matches and the frame length equals max(len, 60)+4 bytes plus the 8-byte preamble.
